// File: rtl/ff_sub.sv
// Limb-serial modular subtractor over GF(2^255-19): out = (a_i - b_i) mod p.
// Optional macro FF_SUB_BUSY_EN adds a busy output for upstream throttling.
module ff_sub #(
  parameter int LIMB_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [254:0] a_i,
  input  logic [254:0] b_i,
  output logic [254:0] out,
  output logic         done
`ifdef FF_SUB_BUSY_EN
  ,
  output logic         busy
`endif
);

  localparam int NLIMBS = 256 / LIMB_W;
  localparam int LW_LOG = $clog2(LIMB_W);
  localparam int CW     = $clog2(NLIMBS + 1);
  localparam logic [CW-1:0] LAST_LIMB = CW'(NLIMBS - 1);
  localparam logic [CW-1:0] ONE_CNT   = CW'(1);
  localparam logic [255:0]  P =
    256'h7fff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffed;
  localparam logic [255:0]  LIMB_MASK = {{(256-LIMB_W){1'b0}}, {LIMB_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic [255:0]    a_op;
  logic [255:0]    b_op;
  logic [255:0]    d_acc;
  logic [255:0]    e_acc;
  logic            borrow;
  logic            carry;
  logic [CW-1:0]   cnt;

  logic [CW-1:0]   add_idx;
  logic [8:0]      sub_sh;
  logic [8:0]      add_sh;
  logic [LIMB_W-1:0] a_limb;
  logic [LIMB_W-1:0] b_limb;
  logic [LIMB_W-1:0] d_limb;
  logic [LIMB_W-1:0] p_limb;
  logic [LIMB_W:0]   diff;
  logic [LIMB_W:0]   sum;
  logic [255:0]    d_next;
  logic [255:0]    e_next;

  // Limb extraction, one-limb subtract/add and merge back into the accumulators.
  // The adder trails the subtractor by one limb (cnt-1), which is NLIMBS-1 in FIX.
  always_comb begin
    add_idx = cnt - ONE_CNT;
    sub_sh  = 9'(cnt) << LW_LOG;
    add_sh  = 9'(add_idx) << LW_LOG;
    a_limb  = LIMB_W'(a_op >> sub_sh);
    b_limb  = LIMB_W'(b_op >> sub_sh);
    d_limb  = LIMB_W'(d_acc >> add_sh);
    p_limb  = LIMB_W'(P >> add_sh);
    diff    = {1'b0, a_limb} - {1'b0, b_limb} - {{LIMB_W{1'b0}}, borrow};
    sum     = {1'b0, d_limb} + {1'b0, p_limb} + {{LIMB_W{1'b0}}, carry};
    d_next  = (d_acc & ~(LIMB_MASK << sub_sh))
            | ({{(256-LIMB_W){1'b0}}, diff[LIMB_W-1:0]} << sub_sh);
    e_next  = (e_acc & ~(LIMB_MASK << add_sh))
            | ({{(256-LIMB_W){1'b0}}, sum[LIMB_W-1:0]} << add_sh);
  end

  // Control FSM with operand capture, limb accumulators and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_op   <= 256'd0;
      b_op   <= 256'd0;
      d_acc  <= 256'd0;
      e_acc  <= 256'd0;
      borrow <= 1'b0;
      carry  <= 1'b0;
      cnt    <= {CW{1'b0}};
      out    <= 255'd0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_op   <= {1'b0, a_i};
            b_op   <= {1'b0, b_i};
            borrow <= 1'b0;
            carry  <= 1'b0;
            cnt    <= {CW{1'b0}};
            state  <= SUB;
          end else begin
            state  <= IDLE;
          end
        end
        SUB: begin
          d_acc  <= d_next;
          borrow <= diff[LIMB_W];
          if (cnt != {CW{1'b0}}) begin
            e_acc <= e_next;
            carry <= sum[LIMB_W];
          end else begin
            carry <= 1'b0;
          end
          cnt <= cnt + ONE_CNT;
          if (cnt == LAST_LIMB) begin
            state <= FIX;
          end else begin
            state <= SUB;
          end
        end
        FIX: begin
          // Carry out of the top limb is dropped: e is taken modulo 2^256.
          e_acc <= e_next;
          carry <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          // borrow still holds the final a-b borrow; the subtractor no longer runs.
          out   <= borrow ? e_acc[254:0] : d_acc[254:0];
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FF_SUB_BUSY_EN
  // Busy covers accept edge through the done cycle; in IDLE it follows start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
    end else if (state == IDLE) begin
      busy <= start;
    end else begin
      busy <= 1'b1;
    end
  end
`endif

endmodule
